// File: rtl/divider.sv
// Restoring radix-2 integer divider that produces one quotient bit per clock.
// It follows RISC-V M-extension result rules and uses a start/busy/done handshake.
module divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             dbz_o,
    output logic [1:0]       state_o
);

    // Handshake: start_i is a request that is taken only in IDLE. The operands
    // are sampled on that edge. busy_o is high from the next cycle through the
    // done_o cycle. done_o pulses for exactly one cycle, and the results stay
    // valid from that cycle until the next operation completes.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIXUP = 2'd2, DONE = 2'd3} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, b_mag;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag_in;
    logic             div_zero, overflow;
    logic [WIDTH:0]   shifted, trial;
    logic             trial_ok;

    always_comb begin
        accept   = (state == IDLE) && start_i;
        a_neg    = signed_i & dividend_i[WIDTH-1];
        b_neg    = signed_i & divisor_i[WIDTH-1];
        a_mag    = a_neg ? -dividend_i : dividend_i;
        b_mag_in = b_neg ? -divisor_i : divisor_i;
        div_zero = (divisor_i == '0);
        overflow = signed_i && (dividend_i == MIN_NEG) && (divisor_i == '1);
        // The partial remainder is always below |b|, so WIDTH+1 bits hold the trial and its sign.
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, b_mag};
        trial_ok = ~trial[WIDTH];
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (div_zero || overflow) ? DONE : RUN;
            RUN:     if (cnt == CW'(1)) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        busy_o  = (state != IDLE);
        done_o  = (state == DONE);
        state_o = state;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            b_mag       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    b_mag <= b_mag_in;
                    quo   <= a_mag;
                    rem   <= '0;
                    cnt   <= CW'(WIDTH);
                    dbz_q <= div_zero;
                    if (div_zero) begin
                        quotient_q  <= '1;
                        remainder_q <= dividend_i;
                    end else if (overflow) begin
                        quotient_q  <= dividend_i;
                        remainder_q <= '0;
                    end
                end
                RUN: begin
                    rem <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], trial_ok};
                    cnt <= cnt - CW'(1);
                end
                FIXUP: begin
                    quotient_q  <= neg_q ? -quo : quo;
                    remainder_q <= neg_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Directed testbench for the 64-bit divider.
// It checks results, latency, the handshake, and reset behaviour against hand-computed values.
module tb_divider;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [63:0] dividend_i = '0;
    logic [63:0] divisor_i = '0;
    logic        busy_o, done_o, dbz_o;
    logic [63:0] quotient_o, remainder_o;
    logic [1:0]  state_o;

    int checks = 0;
    int failures = 0;

    divider #(.WIDTH(64)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .signed_i(signed_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .busy_o(busy_o), .done_o(done_o),
        .quotient_o(quotient_o), .remainder_o(remainder_o), .dbz_o(dbz_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
        end
    endtask

    // Issues one operation and measures latency in cycles after the accept edge.
    // The operands are scrambled after the accept edge, which must have no effect.
    task automatic run_op(input string tag, input logic sgn, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_q,
                          input logic [63:0] exp_r, input logic exp_dbz, input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk_i);
        start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
        @(posedge clk_i);
        #1;
        start_i = 1'b0; dividend_i = ~a; divisor_i = ~b; signed_i = ~sgn;
        lat = 0; seen = 0;
        while (!seen && lat < 200) begin
            @(negedge clk_i);
            lat++;
            if (done_o) seen = 1;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " quotient"}, quotient_o, exp_q);
        check({tag, " remainder"}, remainder_o, exp_r);
        check({tag, " dbz"}, 64'(dbz_o), 64'(exp_dbz));
        check({tag, " busy_at_done"}, 64'(busy_o), 64'd1);
        @(negedge clk_i);
        check({tag, " done_pulse"}, 64'(done_o), 64'd0);
        check({tag, " idle_after"}, 64'(busy_o), 64'd0);
        check({tag, " held_q"}, quotient_o, exp_q);
    endtask

    initial begin
        int ndone;
        int done_at[3];
        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst done", 64'(done_o), 64'd0);
        check("rst dbz", 64'(dbz_o), 64'd0);
        check("rst quotient", quotient_o, 64'd0);
        check("rst remainder", remainder_o, 64'd0);
        check("rst state", 64'(state_o), 64'd0);
        reset_ni = 1'b1;

        run_op("udiv 100/7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 66);
        run_op("sdiv -7/2", 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66);
        run_op("sdiv 7/-2", 1'b1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 66);
        run_op("sdiv -8/-3", 1'b1, -64'sd8, -64'sd3, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66);
        run_op("sdiv 0/-5", 1'b1, 64'd0, -64'sd5, 64'd0, 64'd0, 1'b0, 66);
        run_op("udiv max/16", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16,
               64'h0FFF_FFFF_FFFF_FFFF, 64'd15, 1'b0, 66);
        run_op("udiv dbz", 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1);
        run_op("sdiv dbz", 1'b1, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1);
        run_op("sdiv -5/0", 1'b1, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1);
        run_op("sdiv ovf", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'd0, 1'b0, 1);
        run_op("sdiv min/1", 1'b1, 64'h8000_0000_0000_0000, 64'd1,
               64'h8000_0000_0000_0000, 64'd0, 1'b0, 66);
        run_op("udiv min/max", 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 64'h8000_0000_0000_0000, 1'b0, 66);

        // Hold start_i high through three operations.
        @(negedge clk_i);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 64'd100; divisor_i = 64'd7;
        ndone = 0;
        for (int cyc = 1; cyc <= 240; cyc++) begin
            @(negedge clk_i);
            if (done_o) begin
                if (ndone < 3) done_at[ndone] = cyc;
                ndone++;
                if (ndone == 3) start_i = 1'b0;
            end
        end
        check("b2b pulses", 64'(ndone), 64'd3);
        check("b2b first", 64'(done_at[0]), 64'd66);
        check("b2b gap1", 64'(done_at[1] - done_at[0]), 64'd67);
        check("b2b gap2", 64'(done_at[2] - done_at[1]), 64'd67);
        check("b2b quotient", quotient_o, 64'd14);

        // Reset during RUN discards the operation.
        @(negedge clk_i);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 64'd1000; divisor_i = 64'd3;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        reset_ni = 1'b0;
        #1;
        check("midrst busy", 64'(busy_o), 64'd0);
        check("midrst quotient", quotient_o, 64'd0);
        check("midrst remainder", remainder_o, 64'd0);
        check("midrst dbz", 64'(dbz_o), 64'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk_i);
            if (done_o) ndone++;
        end
        check("midrst no_done", 64'(ndone), 64'd0);
        check("midrst state", 64'(state_o), 64'd0);
        run_op("udiv max/1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
